// File: rtl/periph_filter_pkg.sv
// periph_filter_pkg
//   Shared definitions for the SNES peripheral enable filter:
//   match-mode constants, the per-channel configuration record and
//   helpers that derive index/counter widths from the parameters.
//   The config record carries address fields of CFG_ADDR_W bits; the
//   filter uses the low ADDR_W bits, so ADDR_W must not exceed CFG_ADDR_W.
package periph_filter_pkg;

    localparam logic MODE_ADDR = 1'b0;  // compare against SNES_ADDR
    localparam logic MODE_PA   = 1'b1;  // compare against SNES_PA

    localparam int CFG_ADDR_W = 32;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] base;
        logic [CFG_ADDR_W-1:0] mask;
        logic                  mode;
        logic                  en;
    } chan_cfg_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Stability counter width, wide enough to hold STABLE itself.
    function automatic int cnt_w(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/periph_filter_chan.sv
// periph_filter_chan
//   One address-match window: raw compare, SYNC-deep synchroniser,
//   saturating stability counter, enable decode and start pulse.
// Ports
//   CLK, RST     clock, asynchronous active-high reset
//   snes_addr    SNES bus address (async to CLK)
//   snes_pa      SNES peripheral address (async to CLK)
//   cfg          this channel's registered configuration
//   clr          config write to this channel: clears sync chain and counter
//   enable       filtered enable (registered sources only)
//   start        one-cycle pulse when the count first saturates with en set
module periph_filter_chan
    import periph_filter_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int SYNC   = 2,
    parameter int STABLE = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic [7:0]        snes_pa,
    input  chan_cfg_t         cfg,
    input  logic              clr,
    output logic              enable,
    output logic              start
);

    localparam int            CW      = cnt_w(STABLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

    logic            addr_miss;
    logic            pa_miss;
    logic            raw;
    logic [SYNC-1:0] s;
    logic [CW-1:0]   cnt;
    logic            sat;
    logic            sat_q;

    // A zero mask compares nothing and therefore always matches.
    assign addr_miss = |((snes_addr ^ cfg.base[ADDR_W-1:0]) & cfg.mask[ADDR_W-1:0]);
    assign pa_miss   = |((snes_pa ^ cfg.base[7:0]) & cfg.mask[7:0]);
    assign raw       = (cfg.mode == MODE_PA) ? ~pa_miss : ~addr_miss;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s     <= '0;
            cnt   <= '0;
            sat_q <= 1'b0;
        end else if (clr) begin
            s     <= '0;
            cnt   <= '0;
            sat_q <= 1'b0;
        end else begin
            s[0] <= raw;
            for (int k = 1; k < SYNC; k++)
                s[k] <= s[k-1];
            if (!s[SYNC-1])
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            sat_q <= sat;
        end
    end

    assign sat    = (cnt == CNT_MAX);
    assign enable = cfg.en & sat;
    // sat_q tracks saturation independently of en, so raising en on an
    // already-saturated channel produces no start pulse.
    assign start  = enable & ~sat_q;

endmodule

// File: rtl/periph_enable_filter.sv
// periph_enable_filter
//   Runtime-programmable bank of CHANNELS address-match enable filters
//   for the SNES peripheral decoder, plus a lowest-index priority encoder.
// Ports
//   CLK, RST           clock, asynchronous active-high reset
//   SNES_ADDR, SNES_PA SNES bus/peripheral address (async to CLK)
//   cfg_we, cfg_idx    config write strobe and target channel
//   cfg_base/mask/mode/en  config fields loaded on a write
//   enable, start      per-channel filtered enable and rising pulse
//   any_enable         OR of enable
//   active_idx         lowest asserted channel (0 if none)
//   active_valid       same as any_enable
module periph_enable_filter
    import periph_filter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 24,
    parameter int SYNC     = 2,
    parameter int STABLE   = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [ADDR_W-1:0]             SNES_ADDR,
    input  logic [7:0]                    SNES_PA,
    input  logic                          cfg_we,
    input  logic [idx_w(CHANNELS)-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]             cfg_base,
    input  logic [ADDR_W-1:0]             cfg_mask,
    input  logic                          cfg_mode,
    input  logic                          cfg_en,
    output logic [CHANNELS-1:0]           enable,
    output logic [CHANNELS-1:0]           start,
    output logic                          any_enable,
    output logic [idx_w(CHANNELS)-1:0]    active_idx,
    output logic                          active_valid
);

    localparam int IDX_W = idx_w(CHANNELS);

    chan_cfg_t             cfg_wdata;
    logic [CHANNELS-1:0]   wr_hit;

    assign cfg_wdata.base = CFG_ADDR_W'(cfg_base);
    assign cfg_wdata.mask = CFG_ADDR_W'(cfg_mask);
    assign cfg_wdata.mode = cfg_mode;
    assign cfg_wdata.en   = cfg_en;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        chan_cfg_t cfg_q;

        // Indices at or beyond CHANNELS match no channel, so such writes drop.
        assign wr_hit[i] = cfg_we && (cfg_idx == IDX_W'(i));

        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                cfg_q <= '0;
            else if (wr_hit[i])
                cfg_q <= cfg_wdata;
        end

        periph_filter_chan #(
            .ADDR_W (ADDR_W),
            .SYNC   (SYNC),
            .STABLE (STABLE)
        ) u_chan (
            .CLK       (CLK),
            .RST       (RST),
            .snes_addr (SNES_ADDR),
            .snes_pa   (SNES_PA),
            .cfg       (cfg_q),
            .clr       (wr_hit[i]),
            .enable    (enable[i]),
            .start     (start[i])
        );
    end

    // Scan high to low so the lowest asserted index is the last one written.
    always_comb begin
        active_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (enable[i])
                active_idx = IDX_W'(i);
    end

    assign any_enable   = |enable;
    assign active_valid = any_enable;

endmodule

// File: doc/periph_enable_filter.md
# periph_enable_filter

Parametrised, runtime-programmable successor to the fixed per-peripheral enable filters in the SNES address decoder. It holds CHANNELS address-match windows, each on SNES_ADDR or SNES_PA. Each match is synchronised, then must persist STABLE consecutive cycles before the channel enable asserts. It also produces a one-cycle access-start pulse per channel and a priority-encoded active-channel index for the peripheral mux.

## Interface
- CHANNELS, 4, number of independent match windows (1..16)
- ADDR_W, 24, SNES_ADDR width
- SYNC, 2, synchroniser stages before the stability counter (>=1)
- STABLE, 4, consecutive synchronised matches required to assert (>=1)

- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- SNES_ADDR  in  ADDR_W  SNES bus address (asynchronous to CLK)
- SNES_PA  in  8  SNES peripheral address (asynchronous to CLK)
- cfg_we  in  1  config write strobe
- cfg_idx  in  $clog2(CHANNELS)  channel being written
- cfg_base  in  ADDR_W  compare value (mode PA uses bits [7:0])
- cfg_mask  in  ADDR_W  compare mask; 1 = bit compared
- cfg_mode  in  1  0 = match SNES_ADDR, 1 = match SNES_PA
- cfg_en  in  1  channel feature enable
- enable  out  CHANNELS  filtered per-channel enable
- start  out  CHANNELS  one-cycle pulse on enable rising
- any_enable  out  1  OR of enable
- active_idx  out  $clog2(CHANNELS)  lowest-index asserted channel, 0 if none
- active_valid  out  1  equals any_enable

## Operation
- Per-channel config registers: base, mask, mode, en. All reset to 0, so every channel is disabled after reset.
- Raw match:
  - mode 0: ((SNES_ADDR ^ base) & mask) == 0
  - mode 1: ((SNES_PA ^ base[7:0]) & mask[7:0]) == 0
  - mask = 0 matches everything.
- Raw match passes through a SYNC-deep flop chain, s[0..SYNC-1].
- Counter cnt, width $clog2(STABLE+1):
  - s[SYNC-1] = 1: cnt increments, saturating at STABLE.
  - s[SYNC-1] = 0: cnt clears to 0.
- enable[i] = en[i] & (cnt[i] == STABLE). This is decoded only from registers, with no combinational path from SNES inputs.
- start[i] is high in the single cycle in which cnt[i] first equals STABLE while en[i] = 1. If en rises while cnt is already saturated, no start pulse is issued.
- Config write (cfg_we = 1) to channel k:
  - Loads all four config fields on the next edge.
  - Clears s[] and cnt of channel k on the same edge.
  - enable[k] is therefore 0 from the following cycle.
  - Other channels are unaffected.
- cfg_idx >= CHANNELS: the write is ignored.
- Priority: active_idx is the lowest i with enable[i] = 1. Simultaneous enables are resolved by lowest index.

## Timing
- Reset: all config registers, s[], cnt, enable, start, any_enable, active_idx and active_valid are 0 asynchronously. Deassertion takes effect at the next edge.
- Assert latency: raw match stable from before edge 1 → enable and start high after edge SYNC+STABLE. With the defaults this is edge 6, identical to the legacy 6-flop/&[5:2] filter.
- Deassert latency: raw match low before edge 1 → enable low after edge SYNC+1. With the defaults this is edge 3.
- A glitch of fewer than STABLE cycles never asserts enable. Any single-cycle drop resets the count.
- Reset mid-count: counter returns to 0. After release, the full SYNC+STABLE latency applies again.
- en cleared while enable is high: enable falls in the cycle after the write edge.
- any_enable, active_idx and active_valid are combinational from enable (registered sources), in the same cycle as enable.

## Structure
- Shared package `periph_filter_pkg`:
  - mode constants MODE_ADDR = 0, MODE_PA = 1
  - channel config struct {base, mask, mode, en}
  - clog2-derived width localparams
- Natural sub-module: `periph_filter_chan`, one instance per channel via generate. It contains the compare, sync chain, counter and start logic.
- The top level holds config storage, the write decode and the priority encoder.

## Test plan
- Reset defaults: assert RST mid-run → all outputs 0 immediately. After release, no enable with any address, since all channels are disabled.
- MSU window on ch0 (base 0x002000, mask 0x40FFF8, mode 0, en 1):
  - Hold SNES_ADDR = 0x002003 → enable[0] and start[0] rise after edge 6. start lasts exactly 1 cycle.
  - Change to 0x002008 → enable[0] falls after edge 3.
- Glitch rejection: toggle SNES_ADDR to the match value for 3 cycles, then away → enable[0] stays 0. A fourth consecutive cycle makes it assert.
- PA mode on ch2 (base 0x3F, mask 0xFF, mode 1) together with ch1 (mask 0 = always match):
  - SNES_PA = 0x3F held → both enable.
  - active_idx = 1 until ch1 is reconfigured with en = 0, then active_idx = 2.
- Reconfigure while asserted: write ch0 with the same values while enable[0] = 1 → enable[0] drops in the next cycle, then reasserts with start[0] after a further SYNC+STABLE cycles.
- Parameter sweep: SYNC = 1, STABLE = 1 → assert latency 2 edges, deassert latency 2 edges. CHANNELS = 1 builds with a 1-bit active_idx that is always 0.
